// File: rtl/ap_reg_bank.sv
// Accumulator register bank: 16 working registers addressed by the pointer stage,
// executing load/arithmetic/exchange ops with a valid/ready handshake and Z/C flags.
module ap_reg_bank #(
    parameter int DATA_W = 8,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ap_sel,
    input  logic [2:0]        op,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy
);

    typedef enum logic {IDLE, SWAP2} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_CLR  = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_READ = 3'd7;

    localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ONES = '1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] dout_q, tmp_q;
    logic [3:0]        sel_q;
    logic              z_q, c_q, ready_q;
    state_t            state_q;

    logic [DATA_W-1:0] cur_d, inc_d, dec_d;
    logic [DATA_W:0]   add_d;
    logic              accept;

    always_comb begin
        cur_d  = regs_q[ap_sel];
        inc_d  = cur_d + ONE;
        dec_d  = cur_d - ONE;
        add_d  = {1'b0, cur_d} + {1'b0, din};
        accept = op_valid & ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            dout_q  <= '0;
            tmp_q   <= '0;
            sel_q   <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sel_q <= ap_sel;
                        case (op)
                            OP_LOAD: begin
                                regs_q[ap_sel] <= din;
                                dout_q <= din;
                                z_q    <= (din == '0);
                                c_q    <= 1'b0;
                            end
                            OP_INC: begin
                                regs_q[ap_sel] <= inc_d;
                                dout_q <= inc_d;
                                z_q    <= (inc_d == '0);
                                c_q    <= (cur_d == ONES);
                            end
                            OP_DEC: begin
                                regs_q[ap_sel] <= dec_d;
                                dout_q <= dec_d;
                                z_q    <= (dec_d == '0);
                                c_q    <= (cur_d == '0);
                            end
                            OP_CLR: begin
                                regs_q[ap_sel] <= '0;
                                dout_q <= '0;
                                z_q    <= 1'b1;
                                c_q    <= 1'b0;
                            end
                            OP_SWAP: begin
                                // R0 moves into tmp now; the selected register gets it back next edge
                                tmp_q     <= regs_q[0];
                                regs_q[0] <= cur_d;
                                ready_q   <= 1'b0;
                                state_q   <= SWAP2;
                            end
                            OP_ADD: begin
                                regs_q[ap_sel] <= add_d[DATA_W-1:0];
                                dout_q <= add_d[DATA_W-1:0];
                                z_q    <= (add_d[DATA_W-1:0] == '0);
                                c_q    <= add_d[DATA_W];
                            end
                            OP_READ: begin
                                dout_q <= cur_d;
                                z_q    <= (cur_d == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                SWAP2: begin
                    regs_q[sel_q] <= tmp_q;
                    dout_q  <= tmp_q;
                    z_q     <= (tmp_q == '0);
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign op_ready = ready_q;
    assign busy     = ~ready_q;
    assign dout     = dout_q;
    assign flag_z   = z_q;
    assign flag_c   = c_q;

endmodule

// File: tb/tb_ap_reg_bank.sv
// Directed-vector bench for ap_reg_bank: one task per scenario, inline checks.
module tb_ap_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ap_sel;
    logic [2:0] op;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] din;
    logic [7:0] dout;
    logic       flag_z, flag_c, busy;

    int checks = 0;
    int errors = 0;

    ap_reg_bank #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .ap_sel(ap_sel), .op(op), .op_valid(op_valid),
        .op_ready(op_ready), .din(din), .dout(dout), .flag_z(flag_z),
        .flag_c(flag_c), .busy(busy)
    );

    always #5 clk = ~clk;

    // Present one op, let it be accepted at the next edge, sample 1 ns later.
    task automatic do_op(input logic [3:0] s, input logic [2:0] o, input logic [7:0] d);
        ap_sel = s; op = o; din = d; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", op_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        end
        checks++; if (dout !== 8'h00 || flag_z !== 1'b0 || flag_c !== 1'b0) begin errors++; $display("FAIL reset_out: dout=%h z=%b c=%b want 00 0 0", dout, flag_z, flag_c); end
        rst = 1'b0;
        do_op(4'd5, 3'd7, 8'h00);
        checks++; if (dout !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL reset_read5: dout=%h z=%b c=%b rdy=%b want 00 1 0 1", dout, flag_z, flag_c, op_ready); end
    endtask

    task automatic test_inc_dec();
        do_op(4'd3, 3'd1, 8'hFF);
        checks++; if (dout !== 8'hFF || flag_z !== 1'b0 || flag_c !== 1'b0) begin errors++; $display("FAIL load3: dout=%h z=%b c=%b want ff 0 0", dout, flag_z, flag_c); end
        do_op(4'd3, 3'd2, 8'h00);
        checks++; if (dout !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1) begin errors++; $display("FAIL inc_wrap: dout=%h z=%b c=%b want 00 1 1", dout, flag_z, flag_c); end
        do_op(4'd3, 3'd3, 8'h00);
        checks++; if (dout !== 8'hFF || flag_z !== 1'b0 || flag_c !== 1'b1) begin errors++; $display("FAIL dec_borrow: dout=%h z=%b c=%b want ff 0 1", dout, flag_z, flag_c); end
        do_op(4'd3, 3'd4, 8'h00);
        checks++; if (dout !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b0) begin errors++; $display("FAIL clr: dout=%h z=%b c=%b want 00 1 0", dout, flag_z, flag_c); end
    endtask

    task automatic test_add();
        do_op(4'd2, 3'd1, 8'h90);
        do_op(4'd2, 3'd6, 8'h80);
        checks++; if (dout !== 8'h10 || flag_z !== 1'b0 || flag_c !== 1'b1) begin errors++; $display("FAIL add_carry: dout=%h z=%b c=%b want 10 0 1", dout, flag_z, flag_c); end
        do_op(4'd2, 3'd7, 8'hAA);
        checks++; if (dout !== 8'h10 || flag_z !== 1'b0 || flag_c !== 1'b1) begin errors++; $display("FAIL read2: dout=%h z=%b c=%b want 10 0 1", dout, flag_z, flag_c); end
        do_op(4'd2, 3'd6, 8'h05);
        checks++; if (dout !== 8'h15 || flag_z !== 1'b0 || flag_c !== 1'b0) begin errors++; $display("FAIL add_nocarry: dout=%h z=%b c=%b want 15 0 0", dout, flag_z, flag_c); end
    endtask

    task automatic test_swap();
        do_op(4'd0, 3'd1, 8'h11);
        do_op(4'd7, 3'd1, 8'h77);
        ap_sel = 4'd7; op = 3'd5; din = 8'h00; op_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (op_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL swap_busy: rdy=%b busy=%b want 0 1", op_ready, busy); end
        checks++; if (dout !== 8'h77) begin errors++; $display("FAIL swap_dout_hold: got %h want 77", dout); end
        // Requester moves on to READ R0 but keeps valid high; it must wait out SWAP2.
        ap_sel = 4'd0; op = 3'd7;
        @(posedge clk); #1;
        checks++; if (op_ready !== 1'b1 || dout !== 8'h11 || flag_z !== 1'b0) begin errors++; $display("FAIL swap2: rdy=%b dout=%h z=%b want 1 11 0", op_ready, dout, flag_z); end
        @(posedge clk); #1;
        op_valid = 1'b0;
        checks++; if (dout !== 8'h77 || op_ready !== 1'b1) begin errors++; $display("FAIL swap_r0: dout=%h rdy=%b want 77 1", dout, op_ready); end
        do_op(4'd7, 3'd7, 8'h00);
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL swap_r7: got %h want 11", dout); end
    endtask

    task automatic test_swap_self_and_reset();
        do_op(4'd0, 3'd5, 8'h00);
        checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL swap0_busy: rdy=%b want 0", op_ready); end
        @(posedge clk); #1;
        checks++; if (op_ready !== 1'b1 || dout !== 8'h77) begin errors++; $display("FAIL swap0_done: rdy=%b dout=%h want 1 77", op_ready, dout); end
        do_op(4'd0, 3'd7, 8'h00);
        checks++; if (dout !== 8'h77) begin errors++; $display("FAIL swap0_r0: got %h want 77", dout); end
        do_op(4'd4, 3'd1, 8'h44);
        do_op(4'd4, 3'd5, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (op_ready !== 1'b1 || dout !== 8'h00 || flag_z !== 1'b0 || flag_c !== 1'b0) begin errors++; $display("FAIL swap_rst: rdy=%b dout=%h z=%b c=%b want 1 00 0 0", op_ready, dout, flag_z, flag_c); end
        do_op(4'd0, 3'd7, 8'h00);
        checks++; if (dout !== 8'h00 || flag_z !== 1'b1) begin errors++; $display("FAIL swap_rst_r0: dout=%h z=%b want 00 1", dout, flag_z); end
        do_op(4'd4, 3'd7, 8'h00);
        checks++; if (dout !== 8'h00 || flag_z !== 1'b1) begin errors++; $display("FAIL swap_rst_r4: dout=%h z=%b want 00 1", dout, flag_z); end
        do_op(4'd7, 3'd7, 8'h00);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL swap_rst_r7: got %h want 00", dout); end
    endtask

    task automatic test_idle_inputs();
        do_op(4'd9, 3'd1, 8'hF0);
        do_op(4'd9, 3'd6, 8'h20);
        checks++; if (dout !== 8'h10 || flag_c !== 1'b1) begin errors++; $display("FAIL idle_setup: dout=%h c=%b want 10 1", dout, flag_c); end
        ap_sel = 4'd9; op = 3'd1; din = 8'h00; op_valid = 1'b0;
        @(posedge clk); #1;
        ap_sel = 4'd1; op = 3'd4; din = 8'h33;
        @(posedge clk); #1;
        checks++; if (dout !== 8'h10 || flag_z !== 1'b0 || flag_c !== 1'b1) begin errors++; $display("FAIL idle_ignore: dout=%h z=%b c=%b want 10 0 1", dout, flag_z, flag_c); end
        do_op(4'd9, 3'd0, 8'h00);
        checks++; if (dout !== 8'h10 || flag_z !== 1'b0 || flag_c !== 1'b1) begin errors++; $display("FAIL nop_hold: dout=%h z=%b c=%b want 10 0 1", dout, flag_z, flag_c); end
        do_op(4'd9, 3'd7, 8'h00);
        checks++; if (dout !== 8'h10) begin errors++; $display("FAIL idle_r9: got %h want 10", dout); end
    endtask

    task automatic test_back_to_back();
        do_op(4'd15, 3'd1, 8'hFE);
        ap_sel = 4'd15; op = 3'd2; din = 8'h00; op_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (dout !== 8'hFF || flag_z !== 1'b0 || flag_c !== 1'b0) begin errors++; $display("FAIL b2b_1: dout=%h z=%b c=%b want ff 0 0", dout, flag_z, flag_c); end
        @(posedge clk); #1;
        checks++; if (dout !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1) begin errors++; $display("FAIL b2b_2: dout=%h z=%b c=%b want 00 1 1", dout, flag_z, flag_c); end
        @(posedge clk); #1;
        op_valid = 1'b0;
        checks++; if (dout !== 8'h01 || flag_z !== 1'b0 || flag_c !== 1'b0) begin errors++; $display("FAIL b2b_3: dout=%h z=%b c=%b want 01 0 0", dout, flag_z, flag_c); end
    endtask

    initial begin
        rst = 1'b1; ap_sel = '0; op = '0; op_valid = 1'b0; din = '0;
        #1;
        test_reset();
        test_inc_dec();
        test_add();
        test_swap();
        test_swap_self_and_reset();
        test_idle_inputs();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
